sound_latch_host: RTL and testbench

// - Main-CPU-side endpoint of the main<->sound latch pair; mirrors the sound board's latch logic.
// - Decodes main-CPU I/O accesses and turns each command-port write into a one-cycle

---
 rtl/sound_if_pkg.sv | 17 +
 rtl/reply_fifo.sv | 39 +++
 rtl/sound_latch_host.sv | 81 ++++++++
 tb/tb_sound_latch_host.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sound_if_pkg.sv
// sound_if_pkg: port addresses, status bit layout and reply FSM states shared by the sound latch host.
package sound_if_pkg;
  localparam logic [7:0] DEF_CMD_PORT    = 8'h00;
  localparam logic [7:0] DEF_REPLY_PORT  = 8'h08;
  localparam logic [7:0] DEF_STATUS_PORT = 8'h0a;
  localparam int ST_AVAIL  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_CNT_LO = 2;
  localparam int ST_CNT_HI = 4;
  typedef enum logic [1:0] {REPLY_IDLE, REPLY_ACK, REPLY_WAIT} reply_state_t;
  function automatic logic [7:0] status_byte(input logic [2:0] cnt, input logic full, input logic empty);
    status_byte = 8'h00;
    status_byte[ST_CNT_HI:ST_CNT_LO] = cnt;
    status_byte[ST_FULL] = full;
    status_byte[ST_AVAIL] = ~empty;
  endfunction
endpackage

// File: rtl/reply_fifo.sv
// reply_fifo: synchronous first-word-fall-through FIFO; pushes on full and pops on empty are ignored.
module reply_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk_sys)
    if (do_push) mem[wr_ptr] <= din;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_sys)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/sound_latch_host.sv
// sound_latch_host: main-CPU endpoint of the main<->sound latch pair.
// Decodes I/O accesses, emits command strobes and drains sound replies into a FIFO.
module sound_latch_host import sound_if_pkg::*; #(
  parameter int REPLY_DEPTH = 4,
  parameter logic [7:0] CMD_PORT = DEF_CMD_PORT,
  parameter logic [7:0] REPLY_PORT = DEF_REPLY_PORT,
  parameter logic [7:0] STATUS_PORT = DEF_STATUS_PORT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  io_addr,
  input  logic [15:0] io_din,
  input  logic [1:0]  io_be,
  input  logic        io_wr,
  input  logic        io_rd,
  output logic [7:0]  io_dout,
  output logic        snd_latch_wr,
  output logic [7:0]  snd_latch_din,
  output logic        snd_latch_rd,
  input  logic [7:0]  snd_latch_dout,
  input  logic        snd_latch_rdy,
  output logic        irq_req
);
  localparam int CW = $clog2(REPLY_DEPTH + 1);
  reply_state_t state, state_nx;
  logic io_wr_q, io_rd_q, wr_start, rd_start, rd_end, cmd_go;
  logic [7:0] addr_q, addr, head;
  logic push, pop, full, empty, unused_bits;
  logic [CW-1:0] count;
  assign wr_start = io_wr & ~io_wr_q;
  assign rd_start = io_rd & ~io_rd_q;
  assign rd_end = ~io_rd & io_rd_q;
  // The address seen on the first strobe cycle is held for the rest of the access.
  assign addr = (wr_start | rd_start) ? io_addr : addr_q;
  assign cmd_go = wr_start & (io_addr == CMD_PORT) & io_be[0];
  assign pop = rd_end & (addr_q == REPLY_PORT);
  assign unused_bits = ^{io_din[15:8], io_be[1]};
  always_ff @(posedge clk_sys)
    if (reset) begin
      io_wr_q <= 1'b0;
      io_rd_q <= 1'b0;
      addr_q <= 8'h00;
      snd_latch_wr <= 1'b0;
      snd_latch_din <= 8'h00;
      irq_req <= 1'b0;
    end else begin
      io_wr_q <= io_wr;
      io_rd_q <= io_rd;
      if (wr_start | rd_start) addr_q <= io_addr;
      snd_latch_wr <= cmd_go;
      if (cmd_go) snd_latch_din <= io_din[7:0];
      irq_req <= ~empty;
    end
  always_ff @(posedge clk_sys)
    if (reset) state <= REPLY_IDLE;
    else state <= state_nx;
  // A full FIFO keeps us in IDLE, leaving the reply latched on the sound side.
  always_comb
    state_nx = (state == REPLY_IDLE) ? ((snd_latch_rdy & ~full) ? REPLY_ACK : REPLY_IDLE) :
               (state == REPLY_ACK)  ? REPLY_WAIT :
               (snd_latch_rdy ? REPLY_WAIT : REPLY_IDLE);
  always_comb begin
    push = (state == REPLY_IDLE) & snd_latch_rdy & ~full;
    snd_latch_rd = state == REPLY_ACK;
  end
  always_comb
    io_dout = !io_rd ? 8'hff :
              (addr == REPLY_PORT)  ? (empty ? 8'hff : head) :
              (addr == STATUS_PORT) ? status_byte(3'(count), full, empty) : 8'hff;
  reply_fifo #(.DEPTH(REPLY_DEPTH), .WIDTH(8)) u_fifo (
    .clk_sys(clk_sys),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(snd_latch_dout),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_sound_latch_host.sv
// tb_sound_latch_host: directed and randomized checks of sound_latch_host against a queue-based model.
module tb_sound_latch_host;
  logic clk_sys = 1'b0, reset = 1'b1;
  logic [7:0] io_addr = 8'h00;
  logic [15:0] io_din = 16'h0000;
  logic [1:0] io_be = 2'b00;
  logic io_wr = 1'b0, io_rd = 1'b0;
  logic [7:0] io_dout, snd_latch_din;
  logic snd_latch_wr, snd_latch_rd, irq_req;
  logic [7:0] snd_latch_dout = 8'h00;
  logic snd_latch_rdy = 1'b0;
  int n_checks = 0, n_pass = 0;
  int wr_cnt = 0, rd_cnt = 0, exp_wr = 0, base;
  bit clear_next = 0;
  byte unsigned model_q[$], snd_q[$];
  logic [7:0] last_cmd = 8'h00, d, e, a;

  always #5 clk_sys = ~clk_sys;

  sound_latch_host dut (
    .clk_sys(clk_sys), .reset(reset), .io_addr(io_addr), .io_din(io_din), .io_be(io_be),
    .io_wr(io_wr), .io_rd(io_rd), .io_dout(io_dout), .snd_latch_wr(snd_latch_wr),
    .snd_latch_din(snd_latch_din), .snd_latch_rd(snd_latch_rd), .snd_latch_dout(snd_latch_dout),
    .snd_latch_rdy(snd_latch_rdy), .irq_req(irq_req)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock; the sound side drops rdy one cycle after seeing an ack and then offers its next byte.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (clear_next) begin
      snd_latch_rdy = 1'b0;
      clear_next = 0;
    end else if (!snd_latch_rdy && snd_q.size() > 0) begin
      snd_latch_dout = snd_q.pop_front();
      snd_latch_rdy = 1'b1;
    end
    if (snd_latch_wr) wr_cnt++;
    if (snd_latch_rd) begin
      rd_cnt++;
      model_q.push_back(snd_latch_dout);
      clear_next = 1;
    end
  endtask

  task automatic io_read(input logic [7:0] adr, input int hold, output logic [7:0] dat);
    io_addr = adr;
    io_rd = 1'b1;
    #1;
    dat = io_dout;
    repeat (hold) tick();
    io_rd = 1'b0;
    if (adr == 8'h08 && model_q.size() > 0) void'(model_q.pop_front());
    tick();
  endtask

  task automatic io_write(input logic [7:0] adr, input logic [15:0] dat, input logic [1:0] be, input int hold);
    io_addr = adr;
    io_din = dat;
    io_be = be;
    io_wr = 1'b1;
    repeat (hold) tick();
    io_wr = 1'b0;
    tick();
    if (adr == 8'h00 && be[0]) begin
      exp_wr++;
      last_cmd = dat[7:0];
    end
  endtask

  function automatic logic [7:0] model_status();
    int n = model_q.size();
    return 8'(n * 4 + (n == 4 ? 2 : 0) + (n > 0 ? 1 : 0));
  endfunction

  initial begin
    repeat (3) tick();
    chk("rst_dout", io_dout, 8'hff);
    chk("rst_wr", snd_latch_wr, 0);
    chk("rst_din", snd_latch_din, 0);
    chk("rst_rd", snd_latch_rd, 0);
    chk("rst_irq", irq_req, 0);
    reset = 1'b0;
    tick();

    io_write(8'h00, 16'h1234, 2'b01, 4);
    repeat (2) tick();
    chk("cmd_pulses", wr_cnt, 1);
    chk("cmd_din", snd_latch_din, 8'h34);
    io_write(8'h00, 16'hbeef, 2'b10, 3);
    tick();
    chk("cmd_be10_pulses", wr_cnt, 1);
    chk("cmd_be10_din", snd_latch_din, 8'h34);

    base = rd_cnt;
    snd_q.push_back(8'h5a);
    tick();
    tick();
    chk("cap_irq_early", irq_req, 0);
    tick();
    chk("cap_irq", irq_req, 1);
    repeat (4) tick();
    chk("cap_acks", rd_cnt - base, 1);
    chk("cap_rdy", snd_latch_rdy, 0);
    io_read(8'h0a, 1, d);
    chk("cap_status", d, 8'h05);
    io_read(8'h08, 2, d);
    chk("cap_reply", d, 8'h5a);
    tick();
    chk("cap_irq_off", irq_req, 0);

    base = rd_cnt;
    for (int i = 1; i <= 5; i++) snd_q.push_back(8'(i));
    repeat (40) tick();
    chk("bp_acks", rd_cnt - base, 4);
    io_read(8'h0a, 1, d);
    chk("bp_status", d, 8'h13);
    chk("bp_rdy", snd_latch_rdy, 1);
    for (int i = 1; i <= 5; i++) begin
      io_read(8'h08, 1, d);
      chk("bp_reply", d, 8'(i));
      repeat (6) tick();
    end
    chk("bp_acks_all", rd_cnt - base, 5);

    io_read(8'h08, 1, d);
    chk("empty_reply", d, 8'hff);
    io_read(8'h0a, 1, d);
    chk("empty_status", d, 8'h00);

    snd_q.push_back(8'ha1);
    snd_q.push_back(8'ha2);
    repeat (14) tick();
    io_read(8'h0a, 1, d);
    chk("pp_status_pre", d, 8'h09);
    io_addr = 8'h08;
    io_rd = 1'b1;
    #1;
    chk("pp_head", io_dout, 8'ha1);
    tick();
    io_rd = 1'b0;
    snd_latch_dout = 8'ha3;
    snd_latch_rdy = 1'b1;
    void'(model_q.pop_front());
    tick();
    repeat (4) tick();
    io_read(8'h0a, 1, d);
    chk("pp_status_post", d, 8'h09);
    io_read(8'h08, 1, d);
    chk("pp_order_a2", d, 8'ha2);
    io_read(8'h08, 1, d);
    chk("pp_order_a3", d, 8'ha3);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          if (snd_q.size() < 3) snd_q.push_back(8'($urandom));
          repeat ($urandom_range(1, 3)) tick();
        end
        1: begin
          e = model_q.size() > 0 ? model_q[0] : 8'hff;
          io_read(8'h08, $urandom_range(1, 3), d);
          chk("rnd_reply", d, e);
        end
        2: begin
          e = model_status();
          io_read(8'h0a, $urandom_range(1, 3), d);
          chk("rnd_status", d, e);
        end
        3: begin
          case ($urandom_range(0, 2))
            0: a = 8'h00;
            1: a = 8'h0a;
            default: a = 8'($urandom);
          endcase
          io_write(a, 16'($urandom), 2'($urandom), $urandom_range(1, 4));
          tick();
          chk("rnd_cmd_pulses", wr_cnt, exp_wr);
          chk("rnd_cmd_din", snd_latch_din, last_cmd);
        end
        default: begin
          io_read(8'h09, $urandom_range(1, 2), d);
          chk("rnd_other", d, 8'hff);
        end
      endcase
    end
    for (int k = 0; k < 16; k++) begin
      repeat (6) tick();
      if (model_q.size() == 0 && snd_q.size() == 0 && !snd_latch_rdy) break;
      e = model_q.size() > 0 ? model_q[0] : 8'hff;
      io_read(8'h08, 1, d);
      chk("drain_reply", d, e);
    end
    repeat (2) tick();
    io_read(8'h0a, 1, d);
    chk("drain_status", d, 8'h00);
    tick();
    chk("drain_irq", irq_req, 0);

    snd_q.push_back(8'h77);
    tick();
    tick();
    chk("rst_ack_rd", snd_latch_rd, 1);
    reset = 1'b1;
    tick();
    chk("rst_ack_rd_off", snd_latch_rd, 0);
    chk("rst_ack_irq", irq_req, 0);
    model_q.delete();
    reset = 1'b0;
    base = rd_cnt;
    tick();
    io_read(8'h0a, 1, d);
    chk("rst_ack_status", d, 8'h00);
    repeat (3) tick();
    chk("rst_ack_idle", rd_cnt - base, 0);
    chk("rst_ack_irq_after", irq_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
